// File: rtl/riscv_pkg.sv
// Shared types and constants for the single-cycle RISC-V core.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSN_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: holds {pc, instr} pairs between fetch and decode.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the fetch PC, prefetches into a small FIFO,
// and flushes on execute redirects.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rd,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            redirect_misaligned
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]   r_fetch_pc;
  logic              r_misaligned;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic [2*XLEN-1:0] w_din;
  logic [2*XLEN-1:0] w_dout;

  assign w_pop  = !w_empty & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push = fetch_en & !redirect_valid & (!w_full | w_pop);
  assign w_din  = {r_fetch_pc, imem_rd};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc   <= RESET_PC;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= redirect_valid & (|redirect_pc[1:0]);
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (w_push) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
    end
  end

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_valid),
    .din   (w_din),
    .dout  (w_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign imem_addr           = r_fetch_pc;
  assign out_valid           = (w_count != '0);
  assign out_pc              = w_dout[2*XLEN-1:XLEN];
  assign out_instr           = w_dout[XLEN-1:0];
  assign redirect_misaligned = r_misaligned;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a 16-word instruction ROM image.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_misaligned;

  int errors = 0;
  int checks = 0;

  logic [31:0] rom [16];

  always #5 clk = ~clk;

  assign imem_rd = rom[imem_addr[5:2]];

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .imem_addr           (imem_addr),
    .imem_rd             (imem_rd),
    .fetch_en            (fetch_en),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_instr           (out_instr),
    .out_pc              (out_pc),
    .redirect_misaligned (redirect_misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = INSN_NOP | (32'(i) << 20);
    rom[0]  = 32'h0000_0493;
    rom[1]  = 32'h0000_0413;
    rom[2]  = 32'h00A0_0293;
    rom[5]  = 32'h0000_0413;
    rom[6]  = 32'h0060_0313;
    rom[8]  = 32'h0020_0093;
    rom[15] = 32'hFFF0_0113;

    rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_mis", {31'b0, redirect_misaligned}, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("idle_valid", {31'b0, out_valid}, 32'd0);
    chk("idle_addr", imem_addr, 32'h0);

    // Streaming fetch from reset
    fetch_en = 1'b1; out_ready = 1'b1;
    step();
    chk("s0_valid", {31'b0, out_valid}, 32'd1);
    chk("s0_pc", out_pc, 32'h0);
    chk("s0_instr", out_instr, 32'h0000_0493);
    chk("s0_addr", imem_addr, 32'h4);
    step();
    chk("s1_pc", out_pc, 32'h4);
    chk("s1_instr", out_instr, 32'h0000_0413);
    chk("s1_addr", imem_addr, 32'h8);
    step();
    chk("s2_pc", out_pc, 32'h8);
    chk("s2_instr", out_instr, 32'h00A0_0293);
    chk("s2_addr", imem_addr, 32'hC);

    // Backpressure: FIFO fills to 2, PC stalls, head holds
    out_ready = 1'b0;
    step();
    chk("bp0_addr", imem_addr, 32'h10);
    chk("bp0_pc", out_pc, 32'h8);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_addr_hold", imem_addr, 32'h10);
      chk("bp_pc_hold", out_pc, 32'h8);
      chk("bp_instr_hold", out_instr, 32'h00A0_0293);
    end
    out_ready = 1'b1;
    step();
    chk("rel0_pc", out_pc, 32'hC);
    chk("rel0_addr", imem_addr, 32'h14);
    step();
    chk("rel1_pc", out_pc, 32'h10);
    chk("rel1_addr", imem_addr, 32'h18);

    // Redirect while full to 0x14
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h14;
    step();
    redirect_valid = 1'b0; out_ready = 1'b1;
    chk("rd_valid", {31'b0, out_valid}, 32'd0);
    chk("rd_addr", imem_addr, 32'h14);
    chk("rd_mis", {31'b0, redirect_misaligned}, 32'd0);
    step();
    chk("rd_t_valid", {31'b0, out_valid}, 32'd1);
    chk("rd_t_pc", out_pc, 32'h14);
    chk("rd_t_instr", out_instr, 32'h0000_0413);
    step();
    chk("rd_t1_pc", out_pc, 32'h18);
    chk("rd_t1_instr", out_instr, 32'h0060_0313);

    // Misaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'h22;
    step();
    redirect_valid = 1'b0;
    chk("mis_valid", {31'b0, out_valid}, 32'd0);
    chk("mis_addr", imem_addr, 32'h20);
    chk("mis_pulse", {31'b0, redirect_misaligned}, 32'd1);
    step();
    chk("mis_pulse_off", {31'b0, redirect_misaligned}, 32'd0);
    chk("mis_t_pc", out_pc, 32'h20);
    chk("mis_t_instr", out_instr, 32'h0020_0093);

    // Wrap around top of address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("wr_valid", {31'b0, out_valid}, 32'd0);
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wr_mis", {31'b0, redirect_misaligned}, 32'd0);
    step();
    chk("wr0_pc", out_pc, 32'hFFFF_FFFC);
    chk("wr0_instr", out_instr, 32'hFFF0_0113);
    step();
    chk("wr1_pc", out_pc, 32'h0);
    chk("wr1_instr", out_instr, 32'h0000_0493);
    step();
    chk("wr2_pc", out_pc, 32'h4);
    chk("wr2_addr", imem_addr, 32'h8);

    // fetch_en low: drain, PC holds
    fetch_en = 1'b0;
    step();
    chk("fe0_valid", {31'b0, out_valid}, 32'd0);
    chk("fe0_addr", imem_addr, 32'h8);
    step();
    chk("fe1_addr", imem_addr, 32'h8);

    // Fill to 2 then async reset mid-cycle
    fetch_en = 1'b1; out_ready = 1'b0;
    step();
    step();
    chk("ar_pre_valid", {31'b0, out_valid}, 32'd1);
    chk("ar_pre_pc", out_pc, 32'h8);
    chk("ar_pre_addr", imem_addr, 32'h10);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", {31'b0, out_valid}, 32'd0);
    chk("ar_addr", imem_addr, 32'h0);
    chk("ar_pc", out_pc, 32'h0);
    chk("ar_instr", out_instr, 32'h0);
    fetch_en = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("post_valid", {31'b0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
